// File: rtl/busca_instrucao_pkg.sv
// Shared types and constants for the busca_instrucao instruction fetch stage.
package busca_instrucao_pkg;

  localparam int XLEN       = 64;  // address / PC width
  localparam int INST_W     = 32;  // instruction word width
  localparam int INST_BYTES = 4;   // PC increment per fetched word

  typedef enum logic [1:0] {
    IDLE,     // no request outstanding
    REQ,      // request driven, waiting for imem_ack
    DISCARD   // request outstanding whose response is dropped
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Bus bundle of the fetch stage: instruction-memory req/ack side, redirect
// input, and valid/ready instruction output towards the processing unit.
interface busca_instrucao_if;
  import busca_instrucao_pkg::*;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [XLEN-1:0]   inst_pc;
  logic [XLEN-1:0]   PCOut;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, PCOut,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  // Environment side: instruction memory plus processing unit.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, PCOut,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/busca_instrucao_fetch_fifo.sv
// Prefetch buffer of fetch_entry_t words. Registered storage, head read
// straight from the array so a push in cycle N is visible in cycle N+1.
// The caller must not push into a full buffer unless it pops in the same cycle.
module busca_instrucao_fetch_fifo
  import busca_instrucao_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointer, occupancy and storage update; flush drops every entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset on purpose: it is only a few entries and
      // it makes inst_out/inst_pc read 0 after reset instead of X.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere in clocked blocks, so every
      // register samples the pre-edge values regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns the PC, issues one outstanding req/ack fetch
// at a time, buffers returned words in a small FIFO and accepts redirects.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  busca_instrucao_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int              CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_SLOTS = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW:0]     ONE_SLOT    = (CW + 1)'(1);
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(INST_BYTES - 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic            req_q;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_next_seq;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     free_slots;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect_target = bus.redirect_pc & ALIGN_MASK;
  assign pc_next_seq     = pc + PC_STEP;  // modulo 2^XLEN by construction
  assign pop             = !fifo_empty && bus.inst_ready;
  // Free slots count a same-cycle pop, which lets a full buffer keep streaming.
  assign free_slots      = DEPTH_SLOTS - {1'b0, fifo_count} + {{CW{1'b0}}, pop};
  assign push            = (state == REQ) && bus.imem_ack && !bus.redirect
                           && (!fifo_full || pop);
  assign push_entry      = '{inst: bus.imem_rdata, pc: req_addr};

  busca_instrucao_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = req_addr;
  assign bus.PCOut      = pc;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_out   = head.inst;
  assign bus.inst_pc    = head.pc;

  // Fetch FSM: request issue, PC advance and redirect handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            // Buffer is flushed this edge, so fetching may start right away.
            pc       <= redirect_target;
            req_addr <= redirect_target;
            req_q    <= 1'b1;
            state    <= REQ;
          end else if (free_slots != '0) begin
            req_addr <= pc;
            req_q    <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            pc <= redirect_target;
            if (bus.imem_ack) begin
              // Response of this cycle is dropped; restart at the target.
              req_addr <= redirect_target;
            end else begin
              // Address must stay stable until the old request is acked.
              state <= DISCARD;
            end
          end else if (bus.imem_ack) begin
            pc       <= pc_next_seq;
            req_addr <= pc_next_seq;
            if (free_slots <= ONE_SLOT) begin
              req_q <= 1'b0;
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (bus.redirect) pc <= redirect_target;
          if (bus.imem_ack) begin
            req_addr <= bus.redirect ? redirect_target : pc;
            state    <= REQ;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic dropped_ack;
  assign dropped_ack = bus.imem_ack
                       && ((state == DISCARD) || ((state == REQ) && bus.redirect));

  // Performance counters: delivered and discarded memory responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (push)        perf_fetched <= perf_fetched + 32'd1;
      if (dropped_ack) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: a cycle table for streaming and
// back-pressure, then hand-written redirect, PC wrap and mid-request reset cases.
module tb_busca_instrucao;
  import busca_instrucao_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat = 1;       // memory answers in the lat-th cycle of a request
  int   wait_cnt = 0;
  logic [63:0] delivered[$];

  busca_instrucao_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  busca_instrucao dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: word at address a is 32'h1000_0000 + a[31:0].
  initial begin
    forever begin
      @(negedge clk);
      if (!bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end else begin
        if (bus.imem_ack) wait_cnt = 0;
        wait_cnt++;
        bus.imem_ack   = (wait_cnt >= lat);
        bus.imem_rdata = 32'h1000_0000 + bus.imem_addr[31:0];
      end
    end
  end

  // Record every instruction handed to the processing unit.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.inst_valid && bus.inst_ready) delivered.push_back(bus.inst_pc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] ipc;
    logic [31:0] inst;
    logic [63:0] pcout;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Streaming from reset with ready high, then a second reset with ready
    // low to fill the buffer, hold, and resume.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0,         64'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0,         64'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 32'h0,         64'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 64'h4, 1'b1, 64'h0, 32'h1000_0000, 64'h4};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 64'h8, 1'b1, 64'h4, 32'h1000_0004, 64'h8};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 64'hC, 1'b1, 64'h8, 32'h1000_0008, 64'hC};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0,         64'h0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0,         64'h0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 32'h0,         64'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'h4, 1'b1, 64'h0, 32'h1000_0000, 64'h4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 64'h8, 1'b1, 64'h0, 32'h1000_0000, 64'h8};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 64'h8, 1'b1, 64'h0, 32'h1000_0000, 64'h8};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 64'h8, 1'b1, 64'h0, 32'h1000_0000, 64'h8};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 64'h8, 1'b1, 64'h0, 32'h1000_0000, 64'h8};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 64'h8, 1'b1, 64'h4, 32'h1000_0004, 64'h8};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 64'hC, 1'b1, 64'h8, 32'h1000_0008, 64'hC};

    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    lat             = 1;
    step();

    for (int i = 0; i < 16; i++) begin
      reset          = vecs[i].rst;
      bus.inst_ready = vecs[i].ready;
      #1;
      check($sformatf("row%0d_req", i),   64'(bus.imem_req),   64'(vecs[i].req));
      check($sformatf("row%0d_addr", i),  bus.imem_addr,       vecs[i].addr);
      check($sformatf("row%0d_valid", i), 64'(bus.inst_valid), 64'(vecs[i].valid));
      check($sformatf("row%0d_ipc", i),   bus.inst_pc,         vecs[i].ipc);
      check($sformatf("row%0d_inst", i),  64'(bus.inst_out),   64'(vecs[i].inst));
      check($sformatf("row%0d_pcout", i), bus.PCOut,           vecs[i].pcout);
      step();
    end

    // Redirect to 0x100 while a 3-cycle request to 0 is outstanding.
    reset = 1'b1; lat = 3; bus.inst_ready = 1'b1;
    step();
    reset = 1'b0;
    delivered.delete();
    step();                                   // cycle 1: request at 0
    check("disc_c1_req", 64'(bus.imem_req), 64'h1);
    step();                                   // cycle 2: still waiting
    bus.redirect = 1'b1; bus.redirect_pc = 64'h100;
    check("disc_c2_addr", bus.imem_addr, 64'h0);
    step();                                   // cycle 3: DISCARD, old address held
    bus.redirect = 1'b0;
    check("disc_c3_req", 64'(bus.imem_req), 64'h1);
    check("disc_c3_addr", bus.imem_addr, 64'h0);
    check("disc_c3_pcout", bus.PCOut, 64'h100);
    step();                                   // cycle 4: new request
    check("disc_c4_addr", bus.imem_addr, 64'h100);
    check("disc_c4_valid", 64'(bus.inst_valid), 64'h0);
    step();
    step();                                   // cycle 6
    check("disc_c6_valid", 64'(bus.inst_valid), 64'h0);
    step();                                   // cycle 7: first word delivered
    check("disc_c7_valid", 64'(bus.inst_valid), 64'h1);
    check("disc_c7_ipc", bus.inst_pc, 64'h100);
    check("disc_c7_inst", 64'(bus.inst_out), 64'h1000_0100);
`ifdef FETCH_PERF_EN
    check("disc_perf_fetched", 64'(perf_fetched), 64'h1);
    check("disc_perf_dropped", 64'(perf_dropped), 64'h1);
`endif
    step();
    check("disc_first_delivered", (delivered.size() > 0) ? delivered[0] : '1, 64'h100);

    // Redirect to 0x203 in the same cycle as an ack, with one word buffered.
    reset = 1'b1; lat = 1; bus.inst_ready = 1'b0;
    step();
    reset = 1'b0;
    step();                                   // cycle 1: request at 0
    step();                                   // cycle 2: word 0 buffered, ack for 4
    check("ack_c2_valid", 64'(bus.inst_valid), 64'h1);
    bus.redirect = 1'b1; bus.redirect_pc = 64'h203;
    step();                                   // cycle 3
    bus.redirect = 1'b0;
    check("ack_c3_valid", 64'(bus.inst_valid), 64'h0);
    check("ack_c3_req", 64'(bus.imem_req), 64'h1);
    check("ack_c3_addr", bus.imem_addr, 64'h200);
    check("ack_c3_pcout", bus.PCOut, 64'h200);
    step();                                   // cycle 4
    check("ack_c4_ipc", bus.inst_pc, 64'h200);
    check("ack_c4_inst", 64'(bus.inst_out), 64'h1000_0200);
`ifdef FETCH_PERF_EN
    check("ack_perf_fetched", 64'(perf_fetched), 64'h2);
    check("ack_perf_dropped", 64'(perf_dropped), 64'h1);
`endif

    // Redirect from IDLE to the top word of the address space; PC wraps.
    reset = 1'b1; lat = 1; bus.inst_ready = 1'b1;
    step();
    reset = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();                                   // cycle 1
    bus.redirect = 1'b0;
    check("wrap_c1_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_c1_pcout", bus.PCOut, 64'hFFFF_FFFF_FFFF_FFFC);
    step();                                   // cycle 2
    check("wrap_c2_addr", bus.imem_addr, 64'h0);
    check("wrap_c2_pcout", bus.PCOut, 64'h0);
    check("wrap_c2_ipc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_c2_inst", 64'(bus.inst_out), 64'h0FFF_FFFC);
    step();                                   // cycle 3
    check("wrap_c3_ipc", bus.inst_pc, 64'h0);
    check("wrap_c3_inst", 64'(bus.inst_out), 64'h1000_0000);
    check("wrap_c3_addr", bus.imem_addr, 64'h4);
`ifdef FETCH_PERF_EN
    check("wrap_perf_fetched", 64'(perf_fetched), 64'h2);
`endif

    // Slow memory and no consumer, then reset in the middle of the wait.
    lat = 3; bus.inst_ready = 1'b0;
    step();                                   // cycle 4: waiting on address 4
    check("rst_pre_req", 64'(bus.imem_req), 64'h1);
    check("rst_pre_pcout", bus.PCOut, 64'h4);
    check("rst_pre_valid", 64'(bus.inst_valid), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_req", 64'(bus.imem_req), 64'h0);
    check("rst_async_pcout", bus.PCOut, 64'h0);
    check("rst_async_addr", bus.imem_addr, 64'h0);
    check("rst_async_valid", 64'(bus.inst_valid), 64'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", 64'(perf_fetched), 64'h0);
    check("rst_perf_dropped", 64'(perf_dropped), 64'h0);
`endif
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
